// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets and the per-axis total helper.
// Presets assume the stated pixel clock; CLK_DIV picks that rate from the 50 MHz system clock.
package vga_timing_pkg;

    localparam int VGA640_CLK_DIV  = 2;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@72 runs straight off the 50 MHz clock, so no division
    localparam int SVGA800_CLK_DIV  = 1;
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_core_axis.sv
// One raster axis: wrapping position counter plus raw sync/active decode of the current count.
// Instantiated once for pixels and once for lines; wrap is the carry into the next axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_raw,
    output logic         active_raw
);

    localparam int           TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign wrap       = tick && (count_q == LAST);
    assign sync_raw   = (count_q >= SYNC_START) && (count_q <= SYNC_END);
    assign active_raw = (count_q < ACT_END);

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster timing generator: pixel clock-enable divider, h/v counters,
// registered sync/bright decode with an optional delay line to match the pixel pipeline.
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = VGA640_CLK_DIV,
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 0,
    parameter int CNT_W      = 13
) (
    input  logic             clk50Mhz,
    input  logic             reset,
    input  logic             enable,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             pix_ce,
    output logic             line_start,
    output logic             frame_start
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             pix_ce_w;

    always_comb begin
        div_d = div_q;
        if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk50Mhz or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gated by reset so a CLK_DIV=1 divider cannot report a tick while held in reset
    assign pix_ce_w = enable && reset && (div_q == DIV_LAST);

    logic h_wrap, h_sync_raw, h_active_raw;
    logic v_wrap, v_sync_raw, v_active_raw;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (CNT_W)
    ) h_axis (
        .clk        (clk50Mhz),
        .rst_n      (reset),
        .tick       (pix_ce_w),
        .count      (hCount),
        .wrap       (h_wrap),
        .sync_raw   (h_sync_raw),
        .active_raw (h_active_raw)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (CNT_W)
    ) v_axis (
        .clk        (clk50Mhz),
        .rst_n      (reset),
        .tick       (h_wrap),
        .count      (vCount),
        .wrap       (v_wrap),
        .sync_raw   (v_sync_raw),
        .active_raw (v_active_raw)
    );

    // Stage 0 is the decode register; stages 1..PIPE_DELAY model downstream pixel latency.
    // Bit order within a stage: {h_sync, v_sync, bright}, all active-high internally.
    logic [2:0] stage_q [PIPE_DELAY+1];
    logic [2:0] stage_d [PIPE_DELAY+1];
    logic [2:0] out_bits;

    always_comb begin
        stage_d = stage_q;
        if (pix_ce_w) begin
            stage_d[0] = {h_sync_raw, v_sync_raw, h_active_raw && v_active_raw};
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk50Mhz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_bits    = stage_q[PIPE_DELAY];
    assign hSync       = out_bits[2] ? HS_POL : ~HS_POL;
    assign vSync       = out_bits[1] ? VS_POL : ~VS_POL;
    assign bright      = out_bits[0];

    assign pix_ce      = pix_ce_w;
    assign line_start  = h_wrap;
    assign frame_start = v_wrap;

endmodule

// File: tb/tb_vga_timing_core.sv
// Self-checking bench for vga_timing_core: three instances (default 640x480, tiny CLK_DIV=1 raster,
// PIPE_DELAY=3) checked every clock against a tick-count model, plus table and corner sequences.
module tb_vga_timing_core;

    logic        clk50Mhz;
    logic [2:0]  rstN;
    logic [2:0]  en;
    logic [2:0]  hs, vs, br, pce, ls, fs;
    logic [12:0] hc [3];
    logic [12:0] vc [3];

    localparam int HA  [3] = '{640, 8, 640};
    localparam int HF  [3] = '{16, 1, 16};
    localparam int HSW [3] = '{96, 2, 96};
    localparam int HB  [3] = '{48, 1, 48};
    localparam int VA  [3] = '{480, 4, 480};
    localparam int VF  [3] = '{10, 1, 10};
    localparam int VSW [3] = '{2, 1, 2};
    localparam int VB  [3] = '{33, 1, 33};
    localparam int DIV [3] = '{2, 1, 2};
    localparam int PD  [3] = '{0, 0, 3};

    initial clk50Mhz = 1'b0;
    always #5 clk50Mhz = ~clk50Mhz;

    vga_timing_core dutDef (
        .clk50Mhz(clk50Mhz), .reset(rstN[0]), .enable(en[0]),
        .hSync(hs[0]), .vSync(vs[0]), .bright(br[0]), .hCount(hc[0]), .vCount(vc[0]),
        .pix_ce(pce[0]), .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_core #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dutSmall (
        .clk50Mhz(clk50Mhz), .reset(rstN[1]), .enable(en[1]),
        .hSync(hs[1]), .vSync(vs[1]), .bright(br[1]), .hCount(hc[1]), .vCount(vc[1]),
        .pix_ce(pce[1]), .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_core #(
        .PIPE_DELAY(3)
    ) dutPipe (
        .clk50Mhz(clk50Mhz), .reset(rstN[2]), .enable(en[2]),
        .hSync(hs[2]), .vSync(vs[2]), .bright(br[2]), .hCount(hc[2]), .vCount(vc[2]),
        .pix_ce(pce[2]), .line_start(ls[2]), .frame_start(fs[2])
    );

    typedef struct {
        int   d;
        int   hc;
        int   vc;
        logic hs, vs, br, pce, ls, fs;
    } expT;

    typedef struct {
        logic [2:0] r;
        logic [2:0] e;
        int         cycles;
        int         hc0, vc0, hc1, vc1, hc2, vc2;
    } vecT;

    expT sbQ [$];
    int  nTick [3];
    int  divPh [3];
    int  nTests = 0;
    int  nFail  = 0;
    int  cyc    = 0;

    int   lsLast0 = -1, lsPer0 = -1, pceLast0 = -1, pceGap0 = -1;
    int   hsLowCnt0 = 0, hsLowLen0 = -1, hsFallHc0 = -1;
    logic hsPrev0 = 1'b1;
    int   fsLast1 = -1, fsPer1 = -1, brCnt1 = 0, brFrame1 = -1;
    int   brRiseHc2 = -1, brFallHc2 = -1;
    logic brPrev2 = 1'b0;

    task automatic check(input string what, input int d, input int got, input int want);
        nTests++;
        if (got != want) begin
            nFail++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", what, d, got, want, $time);
        end
    endtask

    // Expected outputs purely from the number of pixel ticks since reset release
    function automatic expT model(input int d, input logic r, input logic e);
        expT x;
        int  ht, vt, n, k, hk, vk;
        ht = HA[d] + HF[d] + HSW[d] + HB[d];
        vt = VA[d] + VF[d] + VSW[d] + VB[d];
        x.d = d; x.hc = 0; x.vc = 0;
        x.hs = 1'b1; x.vs = 1'b1; x.br = 1'b0;
        x.pce = 1'b0; x.ls = 1'b0; x.fs = 1'b0;
        if (r) begin
            n = nTick[d];
            x.hc = n % ht;
            x.vc = (n / ht) % vt;
            k = n - 1 - PD[d];
            if (k >= 0) begin
                hk = k % ht;
                vk = (k / ht) % vt;
                x.hs = !(hk >= HA[d] + HF[d] && hk < HA[d] + HF[d] + HSW[d]);
                x.vs = !(vk >= VA[d] + VF[d] && vk < VA[d] + VF[d] + VSW[d]);
                x.br = (hk < HA[d]) && (vk < VA[d]);
            end
            x.pce = e && (divPh[d] == DIV[d] - 1);
            x.ls  = x.pce && (x.hc == ht - 1);
            x.fs  = x.ls && (x.vc == vt - 1);
        end
        return x;
    endfunction

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] e);
        rstN = r;
        en   = e;
        for (int d = 0; d < 3; d++) begin
            sbQ.push_back(model(d, r[d], e[d]));
        end
    endtask

    task automatic checkOutput();
        expT x;
        while (sbQ.size() > 0) begin
            x = sbQ.pop_front();
            check("hCount", x.d, int'(hc[x.d]), x.hc);
            check("vCount", x.d, int'(vc[x.d]), x.vc);
            check("hSync", x.d, int'(hs[x.d]), int'(x.hs));
            check("vSync", x.d, int'(vs[x.d]), int'(x.vs));
            check("bright", x.d, int'(br[x.d]), int'(x.br));
            check("pix_ce", x.d, int'(pce[x.d]), int'(x.pce));
            check("line_start", x.d, int'(ls[x.d]), int'(x.ls));
            check("frame_start", x.d, int'(fs[x.d]), int'(x.fs));
        end
        if (pce[0]) begin
            if (pceLast0 >= 0 && pceGap0 < 0) pceGap0 = cyc - pceLast0;
            pceLast0 = cyc;
        end
        if (ls[0]) begin
            if (lsLast0 >= 0 && lsPer0 < 0) lsPer0 = cyc - lsLast0;
            lsLast0 = cyc;
        end
        if (hsPrev0 && !hs[0] && hsFallHc0 < 0) hsFallHc0 = int'(hc[0]);
        if (!hs[0]) begin
            hsLowCnt0++;
        end else if (hsLowCnt0 > 0) begin
            if (hsLowLen0 < 0) hsLowLen0 = hsLowCnt0;
            hsLowCnt0 = 0;
        end
        hsPrev0 = hs[0];
        if (fs[1]) begin
            if (fsLast1 >= 0) begin
                fsPer1   = cyc - fsLast1;
                brFrame1 = brCnt1;
            end
            fsLast1 = cyc;
            brCnt1  = 0;
        end
        if (br[1]) brCnt1++;
        if (!brPrev2 && br[2] && brRiseHc2 < 0) brRiseHc2 = int'(hc[2]);
        if (brPrev2 && !br[2] && brFallHc2 < 0) brFallHc2 = int'(hc[2]);
        brPrev2 = br[2];
        cyc++;
    endtask

    task automatic updateModel(input logic [2:0] r, input logic [2:0] e);
        for (int d = 0; d < 3; d++) begin
            if (!r[d]) begin
                nTick[d] = 0;
                divPh[d] = 0;
            end else if (e[d]) begin
                if (divPh[d] == DIV[d] - 1) begin
                    divPh[d] = 0;
                    nTick[d]++;
                end else begin
                    divPh[d]++;
                end
            end
        end
    endtask

    // Drive on the falling edge, compare 1 time unit later, then account for the rising edge
    task automatic runCycle(input logic [2:0] r, input logic [2:0] e);
        @(negedge clk50Mhz);
        applyStimulus(r, e);
        #1;
        checkOutput();
        updateModel(r, e);
    endtask

    vecT vecs [6];

    initial begin
        rstN = 3'b000;
        en   = 3'b000;
        for (int d = 0; d < 3; d++) begin
            nTick[d] = 0;
            divPh[d] = 0;
        end

        vecs[0] = '{r: 3'b000, e: 3'b111, cycles: 5,    hc0: 0,   vc0: 0, hc1: 0, vc1: 0, hc2: 0,   vc2: 0};
        vecs[1] = '{r: 3'b111, e: 3'b111, cycles: 1320, hc0: 660, vc0: 0, hc1: 0, vc1: 5, hc2: 660, vc2: 0};
        vecs[2] = '{r: 3'b111, e: 3'b111, cycles: 500,  hc0: 110, vc0: 1, hc1: 8, vc1: 4, hc2: 110, vc2: 1};
        vecs[3] = '{r: 3'b111, e: 3'b011, cycles: 10,   hc0: 115, vc0: 1, hc1: 6, vc1: 5, hc2: 110, vc2: 1};
        vecs[4] = '{r: 3'b111, e: 3'b111, cycles: 1450, hc0: 40,  vc0: 2, hc1: 4, vc1: 0, hc2: 35,  vc2: 2};
        vecs[5] = '{r: 3'b111, e: 3'b111, cycles: 37,   hc0: 58,  vc0: 2, hc1: 5, vc1: 3, hc2: 53,  vc2: 2};

        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                runCycle(vecs[v].r, vecs[v].e);
            end
            @(posedge clk50Mhz);
            #1;
            check($sformatf("vec%0d hCount", v), 0, int'(hc[0]), vecs[v].hc0);
            check($sformatf("vec%0d vCount", v), 0, int'(vc[0]), vecs[v].vc0);
            check($sformatf("vec%0d hCount", v), 1, int'(hc[1]), vecs[v].hc1);
            check($sformatf("vec%0d vCount", v), 1, int'(vc[1]), vecs[v].vc1);
            check($sformatf("vec%0d hCount", v), 2, int'(hc[2]), vecs[v].hc2);
            check($sformatf("vec%0d vCount", v), 2, int'(vc[2]), vecs[v].vc2);
        end

        // Asynchronous reset of the small raster mid-frame, between clock edges
        #1;
        rstN[1] = 1'b0;
        #1;
        check("async hCount", 1, int'(hc[1]), 0);
        check("async vCount", 1, int'(vc[1]), 0);
        check("async hSync", 1, int'(hs[1]), 1);
        check("async vSync", 1, int'(vs[1]), 1);
        check("async bright", 1, int'(br[1]), 0);
        check("async pix_ce", 1, int'(pce[1]), 0);
        for (int c = 0; c < 3; c++) begin
            runCycle(3'b101, 3'b111);
        end
        for (int i = 0; i < 3; i++) begin
            runCycle(3'b111, 3'b111);
            check("post-reset hCount", 1, int'(hc[1]), i);
            check("post-reset vCount", 1, int'(vc[1]), 0);
        end
        for (int c = 0; c < 200; c++) begin
            runCycle(3'b111, 3'b111);
        end

        check("pix_ce period clks", 0, pceGap0, 2);
        check("line_start period clks", 0, lsPer0, 1600);
        check("hSync low clks", 0, hsLowLen0, 192);
        check("hSync first low hCount", 0, hsFallHc0, 657);
        check("frame_start period clks", 1, fsPer1, 84);
        check("bright clks per frame", 1, brFrame1, 32);
        check("bright rise hCount", 2, brRiseHc2, 4);
        check("bright fall hCount", 2, brFallHc2, 644);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
